// File: rtl/memo_game_sequencer.sv
// rtl/memo_game_sequencer.sv - turn-level controller for the 16-card memory game

module memo_game_sequencer #(
  parameter int N_CARDS     = 16,
  parameter int TURN_CYCLES = 1500,
  parameter int HOLD_CYCLES = 200
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_game,
  input  logic                    sel_valid,
  input  logic [3:0]              sel_idx,
  input  logic [N_CARDS-1:0][4:0] cards,
  input  logic                    done_sh,
  input  logic                    done_mcr,
  input  logic [3:0]              mcr_idx,
  output logic                    start_sh,
  output logic                    start_mcr,
  output logic [3:0]              state,
  output logic [N_CARDS-1:0]      face_up,
  output logic [N_CARDS-1:0]      matched,
  output logic                    player,
  output logic [3:0]              score0,
  output logic [3:0]              score1,
  output logic                    game_over,
  output logic [1:0]              winner
);

  // One shared down-counter serves both the selection timeout and the hold delay.
  localparam int TMAX = (TURN_CYCLES > HOLD_CYCLES) ? TURN_CYCLES : HOLD_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_SHUFFLE = 4'd1,
    S_PICK1   = 4'd2,
    S_PICK2   = 4'd3,
    S_CHECK   = 4'd4,
    S_HOLD    = 4'd5,
    S_RANDOM  = 4'd6,
    S_NEXT    = 4'd7,
    S_OVER    = 4'd8
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [TW-1:0]      r_timer;
  logic [N_CARDS-1:0] r_face_up;
  logic [N_CARDS-1:0] r_matched;
  logic [3:0]         r_first;
  logic [3:0]         r_second;
  logic               r_player;
  logic [3:0]         r_score0;
  logic [3:0]         r_score1;
  logic               r_start_sh;
  logic               r_start_mcr;
  logic               r_game_over;
  logic [1:0]         r_winner;

  logic [N_CARDS-1:0] w_avail;
  logic [N_CARDS-1:0] w_pair_mask;
  logic [3:0]         w_lowest;
  logic [3:0]         w_take_idx;
  logic               w_take;
  logic               w_take_second;
  logic               w_load_turn;
  logic               w_load_hold;
  logic               w_dec;
  logic               w_pair;
  logic               w_unhold;
  logic               w_new_game;

  assign w_avail       = ~(r_face_up | r_matched);
  assign w_pair_mask   = (N_CARDS'(1) << r_first) | (N_CARDS'(1) << r_second);
  // In PICK1 nothing is face-up, so any revealed card means this is the second pick.
  assign w_take_second = |r_face_up;

  // Lowest-index card that is neither revealed nor already paired.
  always_comb begin
    w_lowest = 4'd0;
    for (int i = N_CARDS - 1; i >= 0; i--) begin
      if (w_avail[i]) w_lowest = 4'(i);
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    w_state_next = r_state;
    w_take       = 1'b0;
    w_take_idx   = sel_idx;
    w_load_turn  = 1'b0;
    w_load_hold  = 1'b0;
    w_dec        = 1'b0;
    w_pair       = 1'b0;
    w_unhold     = 1'b0;
    w_new_game   = 1'b0;
    case (r_state)
      S_IDLE, S_OVER: begin
        if (start_game) begin
          w_state_next = S_SHUFFLE;
          w_new_game   = 1'b1;
        end
      end
      S_SHUFFLE: begin
        if (done_sh) begin
          w_state_next = S_PICK1;
          w_load_turn  = 1'b1;
        end
      end
      S_PICK1, S_PICK2: begin
        // A valid selection wins over a timeout landing in the same cycle.
        if (sel_valid && w_avail[sel_idx]) begin
          w_take     = 1'b1;
          w_take_idx = sel_idx;
          if (r_state == S_PICK1) begin
            w_state_next = S_PICK2;
            w_load_turn  = 1'b1;
          end else begin
            w_state_next = S_CHECK;
          end
        end else if (r_timer <= TW'(1)) begin
          w_state_next = S_RANDOM;
        end else begin
          w_dec = 1'b1;
        end
      end
      S_RANDOM: begin
        if (done_mcr) begin
          w_take     = 1'b1;
          w_take_idx = w_avail[mcr_idx] ? mcr_idx : w_lowest;
          if (w_take_second) begin
            w_state_next = S_CHECK;
          end else begin
            w_state_next = S_PICK2;
            w_load_turn  = 1'b1;
          end
        end
      end
      S_CHECK: begin
        if (cards[r_first] == cards[r_second]) begin
          w_state_next = S_NEXT;
          w_pair       = 1'b1;
        end else begin
          w_state_next = S_HOLD;
          w_load_hold  = 1'b1;
        end
      end
      S_HOLD: begin
        if (r_timer <= TW'(1)) begin
          w_state_next = S_NEXT;
          w_unhold     = 1'b1;
        end else begin
          w_dec = 1'b1;
        end
      end
      S_NEXT: begin
        if (&r_matched) begin
          w_state_next = S_OVER;
        end else begin
          w_state_next = S_PICK1;
          w_load_turn  = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  // Timer, card masks, scores, turn ownership and registered strobes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_timer     <= '0;
      r_face_up   <= '0;
      r_matched   <= '0;
      r_first     <= 4'd0;
      r_second    <= 4'd0;
      r_player    <= 1'b0;
      r_score0    <= 4'd0;
      r_score1    <= 4'd0;
      r_start_sh  <= 1'b0;
      r_start_mcr <= 1'b0;
      r_game_over <= 1'b0;
      r_winner    <= 2'd0;
    end else begin
      // Start strobes are high only on the first cycle of their state.
      r_start_sh  <= w_new_game;
      r_start_mcr <= (w_state_next == S_RANDOM) && (r_state != S_RANDOM);
      r_game_over <= (w_state_next == S_OVER);

      if (w_load_turn)      r_timer <= TW'(TURN_CYCLES);
      else if (w_load_hold) r_timer <= TW'(HOLD_CYCLES);
      else if (w_dec)       r_timer <= r_timer - TW'(1);

      if (w_new_game) begin
        r_face_up <= '0;
        r_matched <= '0;
        r_player  <= 1'b0;
        r_score0  <= 4'd0;
        r_score1  <= 4'd0;
        r_winner  <= 2'd0;
      end else begin
        if (w_take) begin
          r_face_up[w_take_idx] <= 1'b1;
          if (w_take_second) r_second <= w_take_idx;
          else               r_first  <= w_take_idx;
        end
        if (w_pair) begin
          r_matched <= r_matched | w_pair_mask;
          r_face_up <= r_face_up & ~w_pair_mask;
          if (r_player == 1'b0) r_score0 <= (r_score0 >= 4'd8) ? r_score0 : r_score0 + 4'd1;
          else                  r_score1 <= (r_score1 >= 4'd8) ? r_score1 : r_score1 + 4'd1;
        end
        if (w_unhold) begin
          r_face_up <= r_face_up & ~w_pair_mask;
          r_player  <= ~r_player;
        end
        if ((w_state_next == S_OVER) && (r_state != S_OVER)) begin
          if (r_score0 > r_score1)      r_winner <= 2'd1;
          else if (r_score1 > r_score0) r_winner <= 2'd2;
          else                          r_winner <= 2'd3;
        end
      end
    end
  end

  assign state     = r_state;
  assign start_sh  = r_start_sh;
  assign start_mcr = r_start_mcr;
  assign face_up   = r_face_up;
  assign matched   = r_matched;
  assign player    = r_player;
  assign score0    = r_score0;
  assign score1    = r_score1;
  assign game_over = r_game_over;
  assign winner    = r_winner;

endmodule

// File: tb/tb_memo_game_sequencer.sv
// tb/tb_memo_game_sequencer.sv - directed table plus randomized games against a game-level model

module tb_memo_game_sequencer;

  localparam int TURN = 40;
  localparam int HOLD = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_game;
  logic             sel_valid;
  logic [3:0]       sel_idx;
  logic [15:0][4:0] cards_v;
  logic             done_sh;
  logic             done_mcr;
  logic [3:0]       mcr_idx;
  logic             start_sh;
  logic             start_mcr;
  logic [3:0]       state;
  logic [15:0]      face_up;
  logic [15:0]      matched;
  logic             player;
  logic [3:0]       score0;
  logic [3:0]       score1;
  logic             game_over;
  logic [1:0]       winner;

  int n_cmp = 0;
  int n_bad = 0;

  memo_game_sequencer #(
    .N_CARDS(16), .TURN_CYCLES(TURN), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk), .rst(rst), .start_game(start_game), .sel_valid(sel_valid),
    .sel_idx(sel_idx), .cards(cards_v), .done_sh(done_sh), .done_mcr(done_mcr),
    .mcr_idx(mcr_idx), .start_sh(start_sh), .start_mcr(start_mcr), .state(state),
    .face_up(face_up), .matched(matched), .player(player), .score0(score0),
    .score1(score1), .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          act;   // 0 = idle ticks, 1 = player select, 2 = random-engine answer
    logic [3:0]  idx;
    int          ticks;
    logic [3:0]  st;
    logic [15:0] fu;
    logic [15:0] mt;
    logic [3:0]  s0;
    logic [3:0]  s1;
    logic        pl;
    logic        smcr;
  } vec_t;

  vec_t tbl [17];

  // Game-level reference model.
  bit [15:0]  m_face;
  bit [15:0]  m_matched;
  int         m_s0;
  int         m_s1;
  bit         m_player;
  logic [4:0] deck [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  task automatic fail_stop(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: expected DUT event did not arrive within bound", nm);
    summary();
    $finish;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pick(input logic [3:0] i);
    sel_idx   = i;
    sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
  endtask

  task automatic play_match(input logic [3:0] a, input logic [3:0] b);
    pick(a);
    pick(b);
    tick();
    tick();
  endtask

  task automatic play_miss(input logic [3:0] a, input logic [3:0] b);
    pick(a);
    pick(b);
    tick();
    repeat (HOLD) tick();
    tick();
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".face_up"}, face_up, m_face);
    chk({tag, ".matched"}, matched, m_matched);
    chk({tag, ".score0"}, score0, m_s0);
    chk({tag, ".score1"}, score1, m_s1);
    chk({tag, ".player"}, player, m_player);
  endtask

  function automatic bit av(input int i);
    return !(m_face[i] || m_matched[i]);
  endfunction

  function automatic int lowest_av();
    int r = -1;
    for (int i = 0; i < 16; i++) if (r < 0 && av(i)) r = i;
    return r;
  endfunction

  // One accepted selection (player or random engine), with ignored attempts along the way.
  task automatic do_pick(input bit second, input int first, output int idx);
    bit accepted = 0;
    int tries = 0;
    int r, c, m, partner;
    int avl[$];
    idx = 0;
    while (!accepted) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        bit seen = 0;
        for (int k = 0; k < TURN + 5 && !seen; k++) begin
          tick();
          if (start_mcr) seen = 1;
        end
        if (!seen) fail_stop("timeout.start_mcr");
        chk("timeout.state", state, 6);
        m = $urandom_range(0, 15);
        mcr_idx  = m[3:0];
        done_mcr = 1'b1;
        tick();
        done_mcr = 1'b0;
        c = av(m) ? m : lowest_av();
        m_face[c] = 1'b1;
        chk("mcr.state", state, second ? 4 : 3);
        chk("mcr.face_up", face_up, m_face);
        idx = c;
        accepted = 1;
      end else begin
        partner = -1;
        if (second)
          for (int j = 0; j < 16; j++) if (j != first && deck[j] == deck[first]) partner = j;
        if (r < 5 && tries < 3) begin
          c = $urandom_range(0, 15);
        end else if (second && partner >= 0 && av(partner) && $urandom_range(0, 1) == 1) begin
          c = partner;
        end else begin
          avl.delete();
          for (int j = 0; j < 16; j++) if (av(j)) avl.push_back(j);
          c = avl[$urandom_range(0, avl.size() - 1)];
        end
        tries++;
        pick(c[3:0]);
        if (av(c)) begin
          m_face[c] = 1'b1;
          chk("sel.state", state, second ? 4 : 3);
          idx = c;
          accepted = 1;
        end else begin
          chk("ignored.state", state, second ? 3 : 2);
        end
        chk("sel.face_up", face_up, m_face);
      end
    end
  endtask

  task automatic run_game();
    int pos[16];
    int a, b, t, exp_w;
    bit over = 0;
    for (int i = 0; i < 16; i++) pos[i] = i;
    for (int i = 15; i > 0; i--) begin
      int j = $urandom_range(0, i);
      int tmp = pos[i];
      pos[i] = pos[j];
      pos[j] = tmp;
    end
    for (int p = 0; p < 8; p++) begin
      logic [4:0] v = 5'(p * 4 + $urandom_range(0, 3));
      deck[pos[2 * p]]     = v;
      deck[pos[2 * p + 1]] = v;
    end
    for (int i = 0; i < 16; i++) cards_v[i] = deck[i];
    m_face = '0; m_matched = '0; m_s0 = 0; m_s1 = 0; m_player = 0;

    start_game = 1'b1;
    tick();
    start_game = 1'b0;
    chk("rg.shuffle.state", state, 1);
    chk("rg.start_sh", start_sh, 1);
    repeat ($urandom_range(0, 5)) tick();
    done_sh = 1'b1;
    tick();
    done_sh = 1'b0;
    chk("rg.pick1.state", state, 2);
    chk_model("rg.start");

    for (t = 0; t < 300 && !over; t++) begin
      chk("rg.turn.state", state, 2);
      do_pick(0, 0, a);
      do_pick(1, a, b);
      if (deck[a] == deck[b]) begin
        tick();
        m_matched[a] = 1'b1; m_matched[b] = 1'b1;
        m_face = '0;
        if (m_player) m_s1++; else m_s0++;
        chk("rg.match.state", state, 7);
        chk_model("rg.match");
        tick();
        if (&m_matched) begin
          chk("rg.over.state", state, 8);
          over = 1;
        end else begin
          chk("rg.after_match.state", state, 2);
        end
      end else begin
        tick();
        chk("rg.hold.state", state, 5);
        chk_model("rg.hold");
        repeat (HOLD) tick();
        m_face = '0;
        m_player = ~m_player;
        chk("rg.next.state", state, 7);
        chk_model("rg.next");
        tick();
      end
    end
    if (!over) fail_stop("rg.game_end");
    exp_w = (m_s0 > m_s1) ? 1 : (m_s1 > m_s0) ? 2 : 3;
    chk("rg.game_over", game_over, 1);
    chk("rg.winner", winner, exp_w);
    chk_model("rg.final");
  endtask

  // Start strobes must be exclusive and single-cycle.
  logic prev_sh = 1'b0;
  logic prev_mcr = 1'b0;
  always @(negedge clk) begin
    if (start_sh || start_mcr) begin
      chk("strobe.exclusive", start_sh & start_mcr, 0);
      chk("strobe.sh_width", start_sh & prev_sh, 0);
      chk("strobe.mcr_width", start_mcr & prev_mcr, 0);
    end
    prev_sh  <= start_sh;
    prev_mcr <= start_mcr;
  end

  initial begin
    #900_000;
    fail_stop("watchdog");
  end

  initial begin
    tbl[0]  = '{1, 4'd0, 0,        4'd3, 16'h0001, 16'h0000, 4'd0, 4'd0, 1'b0, 1'b0};
    tbl[1]  = '{1, 4'd5, 0,        4'd4, 16'h0021, 16'h0000, 4'd0, 4'd0, 1'b0, 1'b0};
    tbl[2]  = '{0, 4'd0, 1,        4'd7, 16'h0000, 16'h0021, 4'd1, 4'd0, 1'b0, 1'b0};
    tbl[3]  = '{0, 4'd0, 1,        4'd2, 16'h0000, 16'h0021, 4'd1, 4'd0, 1'b0, 1'b0};
    tbl[4]  = '{1, 4'd1, 0,        4'd3, 16'h0002, 16'h0021, 4'd1, 4'd0, 1'b0, 1'b0};
    tbl[5]  = '{1, 4'd1, 0,        4'd3, 16'h0002, 16'h0021, 4'd1, 4'd0, 1'b0, 1'b0};
    tbl[6]  = '{1, 4'd2, 0,        4'd4, 16'h0006, 16'h0021, 4'd1, 4'd0, 1'b0, 1'b0};
    tbl[7]  = '{0, 4'd0, 1,        4'd5, 16'h0006, 16'h0021, 4'd1, 4'd0, 1'b0, 1'b0};
    tbl[8]  = '{0, 4'd0, HOLD - 1, 4'd5, 16'h0006, 16'h0021, 4'd1, 4'd0, 1'b0, 1'b0};
    tbl[9]  = '{0, 4'd0, 1,        4'd7, 16'h0000, 16'h0021, 4'd1, 4'd0, 1'b1, 1'b0};
    tbl[10] = '{0, 4'd0, 1,        4'd2, 16'h0000, 16'h0021, 4'd1, 4'd0, 1'b1, 1'b0};
    tbl[11] = '{0, 4'd0, TURN - 1, 4'd2, 16'h0000, 16'h0021, 4'd1, 4'd0, 1'b1, 1'b0};
    tbl[12] = '{0, 4'd0, 1,        4'd6, 16'h0000, 16'h0021, 4'd1, 4'd0, 1'b1, 1'b1};
    tbl[13] = '{2, 4'd0, 0,        4'd3, 16'h0002, 16'h0021, 4'd1, 4'd0, 1'b1, 1'b0};
    tbl[14] = '{1, 4'd3, 0,        4'd4, 16'h000A, 16'h0021, 4'd1, 4'd0, 1'b1, 1'b0};
    tbl[15] = '{0, 4'd0, 1,        4'd7, 16'h0000, 16'h002B, 4'd1, 4'd1, 1'b1, 1'b0};
    tbl[16] = '{0, 4'd0, 1,        4'd2, 16'h0000, 16'h002B, 4'd1, 4'd1, 1'b1, 1'b0};

    // Pairs: (0,5)=7 (1,3)=1 (2,4)=2 (6,7)=3 (8,9)=4 (10,11)=5 (12,13)=6 (14,15)=0
    cards_v[0] = 5'd7;  cards_v[5] = 5'd7;
    cards_v[1] = 5'd1;  cards_v[3] = 5'd1;
    cards_v[2] = 5'd2;  cards_v[4] = 5'd2;
    cards_v[6] = 5'd3;  cards_v[7] = 5'd3;
    cards_v[8] = 5'd4;  cards_v[9] = 5'd4;
    cards_v[10] = 5'd5; cards_v[11] = 5'd5;
    cards_v[12] = 5'd6; cards_v[13] = 5'd6;
    cards_v[14] = 5'd0; cards_v[15] = 5'd0;

    rst = 1'b0; start_game = 0; sel_valid = 0; sel_idx = 0;
    done_sh = 0; done_mcr = 0; mcr_idx = 0;
    tick();
    tick();
    chk("reset.state", state, 0);
    chk("reset.outputs", {start_sh, start_mcr, face_up, matched, player, score0, score1, game_over, winner}, 0);
    rst = 1'b1;
    tick();

    start_game = 1'b1;
    tick();
    start_game = 1'b0;
    chk("start.state", state, 1);
    chk("start.start_sh", start_sh, 1);
    tick();
    chk("start.start_sh_drop", start_sh, 0);
    chk("start.state_wait", state, 1);
    done_sh = 1'b1;
    tick();
    done_sh = 1'b0;
    chk("shuffled.state", state, 2);
    chk("shuffled.masks", {face_up, matched}, 0);

    for (int i = 0; i < 17; i++) begin
      if (tbl[i].act == 1) begin
        pick(tbl[i].idx);
      end else if (tbl[i].act == 2) begin
        mcr_idx  = tbl[i].idx;
        done_mcr = 1'b1;
        tick();
        done_mcr = 1'b0;
      end
      repeat (tbl[i].ticks) tick();
      chk($sformatf("tbl%0d.state", i), state, tbl[i].st);
      chk($sformatf("tbl%0d.face_up", i), face_up, tbl[i].fu);
      chk($sformatf("tbl%0d.matched", i), matched, tbl[i].mt);
      chk($sformatf("tbl%0d.scores", i), {score0, score1}, {tbl[i].s0, tbl[i].s1});
      chk($sformatf("tbl%0d.player", i), player, tbl[i].pl);
      chk($sformatf("tbl%0d.start_mcr", i), start_mcr, tbl[i].smcr);
    end

    play_match(4'd2, 4'd4);
    play_match(4'd6, 4'd7);
    chk("p1.score1", score1, 3);
    chk("p1.player", player, 1);
    start_game = 1'b1;
    tick();
    start_game = 1'b0;
    chk("ignored_start.state", state, 2);
    chk("ignored_start.start_sh", start_sh, 0);
    play_miss(4'd8, 4'd10);
    chk("miss.player", player, 0);
    chk("miss.face_up", face_up, 0);
    chk("miss.state", state, 2);
    play_match(4'd8, 4'd9);
    play_match(4'd10, 4'd11);
    play_match(4'd12, 4'd13);
    play_match(4'd14, 4'd15);
    chk("over.state", state, 8);
    chk("over.game_over", game_over, 1);
    chk("over.winner", winner, 1);
    chk("over.scores", {score0, score1}, {4'd5, 4'd3});
    chk("over.matched", matched, 16'hFFFF);
    tick();
    chk("over.stays", state, 8);

    start_game = 1'b1;
    tick();
    start_game = 1'b0;
    chk("restart.state", state, 1);
    chk("restart.start_sh", start_sh, 1);
    chk("restart.cleared", {matched, score0, score1, game_over, winner}, 0);
    tick();
    done_sh = 1'b1;
    tick();
    done_sh = 1'b0;
    chk("restart.pick1", state, 2);
    pick(4'd1);
    pick(4'd2);
    tick();
    repeat (3) tick();
    chk("midhold.state", state, 5);
    rst = 1'b0;
    tick();
    chk("hold_reset.state", state, 0);
    chk("hold_reset.outputs", {start_sh, start_mcr, face_up, matched, player, score0, score1, game_over, winner}, 0);
    rst = 1'b1;
    done_sh = 1'b1;
    done_mcr = 1'b1;
    tick();
    done_sh = 1'b0;
    done_mcr = 1'b0;
    tick();
    chk("stale_done.state", state, 0);
    chk("stale_done.strobes", {start_sh, start_mcr}, 0);

    for (int g = 0; g < 3; g++) run_game();

    summary();
    $finish;
  end

endmodule
